// File: rtl/trigger_debounce_if.sv
// Button/trigger signal bundle between the debouncer and its environment.
// The slave side is the debouncer itself; the master side drives the raw
// button and observes the trigger/busy outputs.
interface trigger_debounce_if;
    logic btn_in;   // raw, asynchronous, bouncy button level
    logic trigger;  // one-cycle pulse per accepted press
    logic busy;     // high from the pulse until re-arm completes

    modport master (output btn_in, input trigger, input busy);
    modport slave  (input btn_in, output trigger, output busy);
endinterface

// File: rtl/trigger_debounce.sv
// Debounced single-shot trigger: synchronises a bouncy button, qualifies a
// stable press, fires one pulse, holds off for a full counter run and then
// waits for a stable release before accepting the next press.
module trigger_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,   // 1..255
    parameter int HOLDOFF_CYCLES  = 11   // 1..255
) (
    input  logic              clk,
    input  logic              rst_n,
    trigger_debounce_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        FIRE    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // Terminal counts; the parameter range keeps both within 8 bits.
    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    logic   s1_q, btn_s_q;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // Two-flop synchroniser; the FSM only ever looks at btn_s_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s1_q    <= bus.btn_in;
            btn_s_q <= s1_q;
        end
    end

    // State and shared down-path counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is cleared on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS;
                    cnt_d   = 8'd0;
                end
            end
            PRESS: begin
                if (!btn_s_q) begin
                    // Bounce: restart qualification from scratch.
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = FIRE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIRE: begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end
            HOLD: begin
                // Input ignored; a press started here is absorbed by RELEASE.
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                if (btn_s_q) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                // Unused encodings recover to IDLE.
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs decode the state register only, so they cannot glitch.
    assign bus.trigger = (state_q == FIRE);
    assign bus.busy    = (state_q == FIRE) || (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_trigger_debounce.sv
// Directed bench: default instance (D=4, H=11) and a corner instance (D=1, H=1).
// Timing references: "edge 0" is the first rising edge that samples the new
// button level; checks are taken #1 after a rising edge.
module tb_trigger_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trigger_debounce_if i0 ();
    trigger_debounce_if i1 ();

    trigger_debounce #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(11)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(i0.slave));
    trigger_debounce #(.DEBOUNCE_CYCLES(1), .HOLDOFF_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave));

    int total = 0;
    int fails = 0;
    int np0 = 0;
    int np1 = 0;
    int p;

    // Count trigger cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (i0.trigger === 1'b1) np0++;
        if (i1.trigger === 1'b1) np1++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        i0.btn_in = 1'b0;
        i1.btn_in = 1'b0;

        // Reset state
        step(2);
        chk("rst_trig0", 32'(i0.trigger), 0);
        chk("rst_busy0", 32'(i0.busy), 0);
        chk("rst_trig1", 32'(i1.trigger), 0);
        chk("rst_busy1", 32'(i1.busy), 0);
        rst_n = 1'b1;

        // Clean press held 30 cycles: pulse only between edges 6 and 7
        p = np0;
        i0.btn_in = 1'b1;
        step(6);
        chk("clean_e5_trig", 32'(i0.trigger), 0);
        chk("clean_e5_busy", 32'(i0.busy), 0);
        step(1);
        chk("clean_e6_trig", 32'(i0.trigger), 1);
        chk("clean_e6_busy", 32'(i0.busy), 1);
        step(1);
        chk("clean_e7_trig", 32'(i0.trigger), 0);
        chk("clean_e7_busy", 32'(i0.busy), 1);
        step(22);
        chk("clean_held_busy", 32'(i0.busy), 1);
        chk("clean_npulse", 32'(np0 - p), 1);
        // Last edge sampling 1 is edge 29; busy falls D+2 edges later.
        i0.btn_in = 1'b0;
        step(5);
        chk("clean_rel_busy_hi", 32'(i0.busy), 1);
        step(1);
        chk("clean_rel_busy_lo", 32'(i0.busy), 0);

        // Bounce: high 3, low 1, then steady high
        p = np0;
        i0.btn_in = 1'b1;
        step(3);
        i0.btn_in = 1'b0;
        step(1);
        i0.btn_in = 1'b1;           // next edge is edge 0 of the final rise
        step(6);
        chk("bounce_e5_trig", 32'(i0.trigger), 0);
        chk("bounce_no_early", 32'(np0 - p), 0);
        step(1);
        chk("bounce_e6_trig", 32'(i0.trigger), 1);
        step(1);
        chk("bounce_e7_trig", 32'(i0.trigger), 0);
        i0.btn_in = 1'b0;
        step(20);
        chk("bounce_idle_busy", 32'(i0.busy), 0);
        chk("bounce_npulse", 32'(np0 - p), 1);

        // Holdoff: release after pulse, re-press during HOLD for 5 cycles
        p = np0;
        i0.btn_in = 1'b1;
        step(7);
        chk("hold_e6_trig", 32'(i0.trigger), 1);
        step(1);
        chk("hold_e7_trig", 32'(i0.trigger), 0);
        i0.btn_in = 1'b0;
        step(3);
        i0.btn_in = 1'b1;           // sampled at edges 11..15
        step(5);
        i0.btn_in = 1'b0;
        step(6);
        chk("hold_e21_busy", 32'(i0.busy), 1);  // HOLD ends at 18, RELEASE 19..21
        step(1);
        chk("hold_e22_busy", 32'(i0.busy), 0);
        step(10);
        chk("hold_npulse", 32'(np0 - p), 1);

        // Long hold: 200 cycles high, one pulse only
        p = np0;
        i0.btn_in = 1'b1;
        step(200);
        i0.btn_in = 1'b0;           // last edge sampling 1 is edge 199
        step(5);
        chk("long_busy_hi", 32'(i0.busy), 1);
        step(1);
        chk("long_busy_lo", 32'(i0.busy), 0);
        chk("long_npulse", 32'(np0 - p), 1);

        // Next press pulses normally, then reset mid-pulse
        i0.btn_in = 1'b1;
        step(6);
        chk("next_e5_trig", 32'(i0.trigger), 0);
        step(1);
        chk("next_e6_trig", 32'(i0.trigger), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_trig", 32'(i0.trigger), 0);
        chk("rstmid_busy", 32'(i0.busy), 0);
        i0.btn_in = 1'b0;
        step(2);
        chk("rstmid_hold_busy", 32'(i0.busy), 0);
        rst_n = 1'b1;
        p = np0;
        i0.btn_in = 1'b1;
        step(6);
        chk("post_rst_e5_trig", 32'(i0.trigger), 0);
        step(1);
        chk("post_rst_e6_trig", 32'(i0.trigger), 1);
        chk("post_rst_e6_busy", 32'(i0.busy), 1);
        step(1);
        chk("post_rst_e7_trig", 32'(i0.trigger), 0);
        i0.btn_in = 1'b0;
        step(25);
        chk("post_rst_idle", 32'(i0.busy), 0);
        chk("post_rst_npulse", 32'(np0 - p), 1);

        // Corners D=1, H=1: release right after pulse
        p = np1;
        i1.btn_in = 1'b1;
        step(3);
        chk("c_e2_trig", 32'(i1.trigger), 0);
        chk("c_e2_busy", 32'(i1.busy), 0);
        step(1);
        chk("c_e3_trig", 32'(i1.trigger), 1);
        chk("c_e3_busy", 32'(i1.busy), 1);
        i1.btn_in = 1'b0;           // last edge sampling 1 is edge 3
        step(1);
        chk("c_e4_trig", 32'(i1.trigger), 0);
        chk("c_e4_busy", 32'(i1.busy), 1);   // HOLD, one cycle
        step(1);
        chk("c_e5_busy", 32'(i1.busy), 1);   // RELEASE
        step(1);
        chk("c_e6_busy", 32'(i1.busy), 0);   // one low sample re-arms
        chk("c_npulse", 32'(np1 - p), 1);

        // Corners: held past the pulse, release re-arms after one low sample
        i1.btn_in = 1'b1;
        step(4);
        chk("c2_e3_trig", 32'(i1.trigger), 1);
        step(4);
        i1.btn_in = 1'b0;           // last edge sampling 1 is edge 7
        step(2);
        chk("c2_e9_busy", 32'(i1.busy), 1);
        step(1);
        chk("c2_e10_busy", 32'(i1.busy), 0);
        chk("c2_npulse", 32'(np1 - p), 2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
